// File: rtl/axi_lite_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_arbiter_if
// Single-beat command bus between the arbiter and an AXI4-Lite master engine.
//   cmd_valid : request to the master, held high until cmd_done
//   cmd_write : 1 = write, 0 = read
//   cmd_addr  : command address
//   cmd_wdata : write data
//   cmd_rdata : read data from the master, valid with cmd_done
//   cmd_done  : one-cycle completion from the master
// Modports:
//   master : the arbiter side (drives the command, receives completion)
//   slave  : the master-engine side (receives the command, drives completion)
// ---------------------------------------------------------------------------
interface axi_lite_cmd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              cmd_valid;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] cmd_rdata;
    logic              cmd_done;

    modport master (
        output cmd_valid,
        output cmd_write,
        output cmd_addr,
        output cmd_wdata,
        input  cmd_rdata,
        input  cmd_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_write,
        input  cmd_addr,
        input  cmd_wdata,
        output cmd_rdata,
        output cmd_done
    );
endinterface

// File: rtl/axi_lite_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_arbiter
// Round-robin arbiter sharing one single-beat command port among N_REQ
// requesters. One transaction at a time: IDLE -> ISSUE -> RELEASE -> IDLE.
// Ports:
//   ACLK, ARESET          : clock, synchronous active-high reset
//   req_valid/req_write   : per-requester request and direction
//   req_addr/req_wdata    : packed per-requester address / write data
//   req_done              : one-hot one-cycle completion pulse
//   req_rdata             : read data of the last completed transaction
//   grant_id              : current/last granted requester
//   busy                  : high in ISSUE and RELEASE
//   cmd                   : command bus to the master (interface, master side)
//   timeout_err           : sticky stall watchdog flag
//   txn_count             : completed transaction counter (wraps)
// All outputs are registered.
// ---------------------------------------------------------------------------
module axi_lite_cmd_arbiter #(
    parameter int  N_REQ   = 4,
    parameter int  ADDR_W  = 32,
    parameter int  DATA_W  = 64,
    parameter int  TIMEOUT = 256,
    localparam int IDX_W   = $clog2(N_REQ),
    localparam int WD_W    = $clog2(TIMEOUT + 1)
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_done,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    axi_lite_cmd_arbiter_if.master    cmd,
    output logic                      timeout_err,
    output logic [31:0]               txn_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [IDX_W-1:0]  ptr_r,        ptr_nxt_s;
    logic              cmd_valid_r,  cmd_valid_nxt_s;
    logic              cmd_write_r,  cmd_write_nxt_s;
    logic [ADDR_W-1:0] cmd_addr_r,   cmd_addr_nxt_s;
    logic [DATA_W-1:0] cmd_wdata_r,  cmd_wdata_nxt_s;
    logic [N_REQ-1:0]  req_done_r,   req_done_nxt_s;
    logic [DATA_W-1:0] req_rdata_r,  req_rdata_nxt_s;
    logic [IDX_W-1:0]  grant_id_r,   grant_id_nxt_s;
    logic              busy_r,       busy_nxt_s;
    logic              timeout_r,    timeout_nxt_s;
    logic [31:0]       txn_count_r,  txn_count_nxt_s;
    logic [WD_W-1:0]   wd_cnt_r,     wd_cnt_nxt_s;

    logic              found_s;
    logic [IDX_W-1:0]  winner_s;
    logic              win_write_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;

    // (base + off) mod N_REQ; works for non-power-of-two N_REQ
    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base,
                                                 input logic [IDX_W-1:0] off);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (IDX_W+1)'(N_REQ)) begin
            sum = sum - (IDX_W+1)'(N_REQ);
        end else begin
            sum = sum;
        end
        return sum[IDX_W-1:0];
    endfunction

    // Round-robin scan: first pending requester at or after the pointer
    always_comb begin
        logic [IDX_W-1:0] cand_v;
        logic             hit_v;
        found_s  = 1'b0;
        winner_s = '0;
        cand_v   = '0;
        hit_v    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_v   = idx_add(ptr_r, IDX_W'(k));
            hit_v    = !found_s && req_valid[cand_v];
            winner_s = hit_v ? cand_v : winner_s;
            found_s  = found_s | hit_v;
        end
    end

    // Select the winning requester's command fields
    always_comb begin
        logic sel_v;
        win_write_s = 1'b0;
        win_addr_s  = '0;
        win_wdata_s = '0;
        sel_v       = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_v       = (winner_s == IDX_W'(i));
            win_write_s = sel_v ? req_write[i]                   : win_write_s;
            win_addr_s  = sel_v ? req_addr[i*ADDR_W +: ADDR_W]   : win_addr_s;
            win_wdata_s = sel_v ? req_wdata[i*DATA_W +: DATA_W]  : win_wdata_s;
        end
    end

    // FSM state register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cmd.cmd_done) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_RELEASE: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode: next values of every registered output
    always_comb begin
        ptr_nxt_s       = ptr_r;
        cmd_valid_nxt_s = cmd_valid_r;
        cmd_write_nxt_s = cmd_write_r;
        cmd_addr_nxt_s  = cmd_addr_r;
        cmd_wdata_nxt_s = cmd_wdata_r;
        req_done_nxt_s  = '0;
        req_rdata_nxt_s = req_rdata_r;
        grant_id_nxt_s  = grant_id_r;
        timeout_nxt_s   = timeout_r;
        txn_count_nxt_s = txn_count_r;
        wd_cnt_nxt_s    = wd_cnt_r;
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    cmd_valid_nxt_s = 1'b1;
                    cmd_write_nxt_s = win_write_s;
                    cmd_addr_nxt_s  = win_addr_s;
                    cmd_wdata_nxt_s = win_wdata_s;
                    grant_id_nxt_s  = winner_s;
                    wd_cnt_nxt_s    = '0;
                end else begin
                    cmd_valid_nxt_s = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (cmd.cmd_done) begin
                    req_rdata_nxt_s             = cmd.cmd_rdata;
                    req_done_nxt_s[grant_id_r]  = 1'b1;
                    cmd_valid_nxt_s             = 1'b0;
                    ptr_nxt_s                   = idx_add(grant_id_r, IDX_W'(1));
                    txn_count_nxt_s             = txn_count_r + 32'd1;
                end else begin
                    // Watchdog saturates at TIMEOUT; the flag is sticky
                    if (wd_cnt_r != WD_W'(TIMEOUT)) begin
                        wd_cnt_nxt_s = wd_cnt_r + WD_W'(1);
                    end else begin
                        wd_cnt_nxt_s = wd_cnt_r;
                    end
                    if (wd_cnt_r == WD_W'(TIMEOUT - 1)) begin
                        timeout_nxt_s = 1'b1;
                    end else begin
                        timeout_nxt_s = timeout_r;
                    end
                end
            end
            ST_RELEASE: cmd_valid_nxt_s = 1'b0;
            default:    cmd_valid_nxt_s = 1'b0;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ptr_r       <= '0;
            cmd_valid_r <= 1'b0;
            cmd_write_r <= 1'b0;
            cmd_addr_r  <= '0;
            cmd_wdata_r <= '0;
            req_done_r  <= '0;
            req_rdata_r <= '0;
            grant_id_r  <= '0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
            txn_count_r <= 32'd0;
            wd_cnt_r    <= '0;
        end else begin
            ptr_r       <= ptr_nxt_s;
            cmd_valid_r <= cmd_valid_nxt_s;
            cmd_write_r <= cmd_write_nxt_s;
            cmd_addr_r  <= cmd_addr_nxt_s;
            cmd_wdata_r <= cmd_wdata_nxt_s;
            req_done_r  <= req_done_nxt_s;
            req_rdata_r <= req_rdata_nxt_s;
            grant_id_r  <= grant_id_nxt_s;
            busy_r      <= busy_nxt_s;
            timeout_r   <= timeout_nxt_s;
            txn_count_r <= txn_count_nxt_s;
            wd_cnt_r    <= wd_cnt_nxt_s;
        end
    end

    assign cmd.cmd_valid = cmd_valid_r;
    assign cmd.cmd_write = cmd_write_r;
    assign cmd.cmd_addr  = cmd_addr_r;
    assign cmd.cmd_wdata = cmd_wdata_r;
    assign req_done      = req_done_r;
    assign req_rdata     = req_rdata_r;
    assign grant_id      = grant_id_r;
    assign busy          = busy_r;
    assign timeout_err   = timeout_r;
    assign txn_count     = txn_count_r;

endmodule

// File: doc/axi_lite_cmd_arbiter.md
Name: axi_lite_cmd_arbiter

Overview:
- Round-robin arbiter that shares one axi4_lite_master command port (cmd_valid/cmd_write/cmd_addr/cmd_wdata/cmd_rdata/cmd_done) among N_REQ requesters.
- Sequences one single-beat read or write at a time.
- Returns read data and a completion pulse to the granted requester.
- Provides a stall watchdog, a busy flag and a transaction counter.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 64, data width
TIMEOUT, 256, ISSUE-state cycles without cmd_done before timeout_err is set (>=2)

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous reset, active-high
req_valid  in  N_REQ  per-requester request, held until its req_done
req_write  in  N_REQ  per-requester 1=write, 0=read
req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  packed write data, same packing
req_done  out  N_REQ  one-hot one-cycle completion pulse
req_rdata  out  DATA_W  read data of last completed transaction, valid with req_done
grant_id  out  $clog2(N_REQ)  index of current/last granted requester
busy  out  1  high in ISSUE and RELEASE
cmd_valid  out  1  to master; held high until cmd_done
cmd_write  out  1  to master
cmd_addr  out  ADDR_W  to master
cmd_wdata  out  DATA_W  to master
cmd_rdata  in  DATA_W  from master, valid with cmd_done
cmd_done  in  1  from master, completion
timeout_err  out  1  sticky watchdog flag
txn_count  out  32  completed transactions, wraps 2^32-1 -> 0

Behaviour:
- Reset (ARESET high at a rising edge):
  - All outputs go to 0: cmd_*, req_done, req_rdata, grant_id, busy, timeout_err, txn_count.
  - RR pointer goes to 0; state goes to IDLE.
  - Reset mid-transaction abandons it: no req_done, no counter increment. The master is reset by the same system reset.
- State machine: IDLE -> ISSUE -> RELEASE -> IDLE.
- IDLE:
  - If any req_valid is set, select the first set bit at or after the pointer, scanning upward with wrap modulo N_REQ.
  - On the edge, register cmd_addr/cmd_wdata/cmd_write from the winner, set cmd_valid=1 and grant_id=winner, go to ISSUE.
  - Latency: req_valid sampled high at edge k gives cmd_valid high after edge k.
  - If no request is pending, stay in IDLE with cmd_valid=0.
- ISSUE:
  - cmd_* stay stable, and requester inputs are ignored (they are latched). Changes to req_valid of other requesters have no effect on the current transaction.
  - On an edge where cmd_done=1:
    - req_rdata <= cmd_rdata (writes also capture it, value don't-care).
    - req_done[grant_id] <= 1.
    - cmd_valid <= 0.
    - pointer <= (grant_id+1) mod N_REQ.
    - txn_count increments.
    - Go to RELEASE.
- RELEASE:
  - Lasts exactly 1 cycle with cmd_valid=0. This guarantees the master sees valid drop between commands.
  - req_done is high for this cycle only, then returns to 0 on the exit edge. Go to IDLE.
- Requester contract:
  - Deassert req_valid on the edge where req_done is sampled high.
  - If req_valid is still high in IDLE, it is treated as a new request. This is legal back-to-back use, subject to round-robin order.
- Throughput: minimum 3 cycles per transaction plus master latency. The arbiter introduces no gaps beyond IDLE and RELEASE.
- Fairness: the winner becomes lowest priority next time. With all N_REQ requesting continuously, grants rotate 0,1,..,N-1,0.
- Simultaneous events: arbitration happens only in IDLE. The arbiter never issues a new command while cmd_done is high.
- Watchdog:
  - A counter clears on entry to ISSUE and increments every ISSUE cycle without cmd_done.
  - When it reaches TIMEOUT, timeout_err is set to 1. It stays at 1 until reset.
  - The transaction continues to wait for cmd_done; there is no abort.
- cmd_done outside ISSUE is ignored.

Test Plan:
- Single write, then read from the same requester:
  - Requester 0 writes addr 0x20, data 0x1111_2222_3333_4444 -> one cmd_valid assertion, req_done=4'b0001 for 1 cycle, txn_count=1.
  - Requester 0 then reads 0x20 -> req_rdata=0x1111_2222_3333_4444, txn_count=2.
- Simultaneous requests:
  - All 4 requesters assert req_valid at the same edge with distinct addrs 0x100/0x200/0x300/0x400 -> grants in order 0,1,2,3; each req_done one-hot in that order.
  - cmd_valid is low for >=1 cycle between commands.
- Round-robin fairness:
  - Requesters 1 and 3 keep req_valid high for 6 transactions -> grant_id sequence 1,3,1,3,1,3.
  - Requester 0 joining mid-stream after a grant to 3 is served next.
- Watchdog:
  - TIMEOUT=8; the master model withholds cmd_done for 20 cycles -> timeout_err rises exactly 8 ISSUE cycles after cmd_valid; the transaction still completes with req_done.
  - timeout_err stays 1 until ARESET.
- Reset mid-transaction:
  - Assert ARESET in ISSUE -> next cycle all outputs are 0 and state is IDLE; no req_done pulse.
  - After release, requester 2 alone is granted first (pointer = 0, scan upward).
- Counter wrap:
  - Force txn_count to 0xFFFF_FFFF via hierarchical deposit, complete one transaction -> txn_count=0.
